// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file write arbiter slice.
// Imported by rf_write_arbiter and rf_scoreboard.
package rf_arb_pkg;

   localparam int unsigned XLEN             = 32;
   localparam int unsigned REG_AW           = 5;
   localparam int unsigned NUM_REGS         = 1 << REG_AW;
   localparam int unsigned STARVE_LIMIT_DEF = 4;

   typedef enum logic {
      PRIO_WB = 1'b0,
      PRIO_LU = 1'b1
   } arb_state_e;

   function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [REG_AW-1:0] addr);
      logic [NUM_REGS-1:0] vec;
      vec       = '0;
      vec[addr] = 1'b1;
      return vec;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write tracking for long-latency destinations, plus a sticky error
// flag raised when an LU completion targets a register that was not pending.
module rf_scoreboard
   import rf_arb_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                set,
   input  logic [REG_AW-1:0]   set_addr,
   input  logic                clr,
   input  logic [REG_AW-1:0]   clr_addr,
   output logic [NUM_REGS-1:0] busy_mask,
   output logic                err
);

   logic [NUM_REGS-1:0] set_vec;
   logic [NUM_REGS-1:0] clr_vec;
   logic [NUM_REGS-1:0] busy_nxt;
   logic                orphan;

   // Set is applied after clear so a same-cycle reissue keeps the bit pending.
   always_comb begin
      set_vec     = set ? addr_onehot(set_addr) : '0;
      clr_vec     = clr ? addr_onehot(clr_addr) : '0;
      busy_nxt    = (busy_mask & ~clr_vec) | set_vec;
      busy_nxt[0] = 1'b0;
   end

   assign orphan = clr && (clr_addr != '0) && !busy_mask[clr_addr];

   always_ff @(posedge clk) begin
      if (rst) begin
         busy_mask <= '0;
         err       <= 1'b0;
      end else begin
         busy_mask <= busy_nxt;
         if (orphan) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates the single register-file write port between pipeline write-back
// and a long-latency unit, with starvation-driven priority swap to the LU.
module rf_write_arbiter
   import rf_arb_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wb_valid,
   output logic                wb_ready,
   input  logic [REG_AW-1:0]   wb_addr,
   input  logic [XLEN-1:0]     wb_data,
   input  logic                lu_valid,
   output logic                lu_ready,
   input  logic [REG_AW-1:0]   lu_addr,
   input  logic [XLEN-1:0]     lu_data,
   input  logic                issue_valid,
   input  logic [REG_AW-1:0]   issue_addr,
   output logic                reg_write,
   output logic [REG_AW-1:0]   write_addr,
   output logic [XLEN-1:0]     write_data,
   output logic [NUM_REGS-1:0] busy_mask,
   output logic                err
);

   localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

   arb_state_e    state;
   logic [CW-1:0] lu_wait;
   logic [CW-1:0] lu_wait_nxt;
   logic          wb_hs;
   logic          lu_hs;

   always_comb begin
      wb_ready = 1'b0;
      lu_ready = 1'b0;
      if (!rst) begin
         case (state)
            PRIO_WB: begin
               wb_ready = wb_valid;
               lu_ready = lu_valid && !wb_valid;
            end
            PRIO_LU: begin
               lu_ready = lu_valid;
               wb_ready = wb_valid && !lu_valid;
            end
            default: begin
               wb_ready = 1'b0;
               lu_ready = 1'b0;
            end
         endcase
      end
   end

   assign wb_hs = wb_valid && wb_ready;
   assign lu_hs = lu_valid && lu_ready;

   always_comb begin
      lu_wait_nxt = lu_wait;
      if (!lu_valid || lu_hs) begin
         lu_wait_nxt = '0;
      end else if (lu_wait != LIMIT) begin
         lu_wait_nxt = lu_wait + CW'(1);
      end
   end

   // Swap keys off the counter's next value so the LU wins right after the
   // STARVE_LIMIT-th lost cycle rather than one cycle later.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= PRIO_WB;
         lu_wait <= '0;
      end else begin
         lu_wait <= lu_wait_nxt;
         case (state)
            PRIO_WB: if (lu_wait_nxt == LIMIT) state <= PRIO_LU;
            PRIO_LU: if (lu_hs) state <= PRIO_WB;
            default: state <= PRIO_WB;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         reg_write  <= 1'b0;
         write_addr <= '0;
         write_data <= '0;
      end else begin
         reg_write <= 1'b0;
         if (wb_hs) begin
            reg_write  <= (wb_addr != '0);
            write_addr <= wb_addr;
            write_data <= wb_data;
         end else if (lu_hs) begin
            reg_write  <= (lu_addr != '0);
            write_addr <= lu_addr;
            write_data <= lu_data;
         end
      end
   end

   rf_scoreboard u_scoreboard (
      .clk       (clk),
      .rst       (rst),
      .set       (issue_valid),
      .set_addr  (issue_addr),
      .clr       (lu_hs),
      .clr_addr  (lu_addr),
      .busy_mask (busy_mask),
      .err       (err)
   );

   a_single_grant: assert property (@(posedge clk) !(wb_ready && lu_ready));
   a_ready_needs_valid: assert property (@(posedge clk)
      (!wb_ready || wb_valid) && (!lu_ready || lu_valid));

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Scoreboard bench for rf_write_arbiter: directed grant expectations per cycle,
// expected write-port / busy / err results queued and compared after the edge.
module tb_rf_write_arbiter;

   logic        clk;
   logic        rst;
   logic        wb_valid;
   logic        wb_ready;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        lu_valid;
   logic        lu_ready;
   logic [4:0]  lu_addr;
   logic [31:0] lu_data;
   logic        issue_valid;
   logic [4:0]  issue_addr;
   logic        reg_write;
   logic [4:0]  write_addr;
   logic [31:0] write_data;
   logic [31:0] busy_mask;
   logic        err;

   typedef struct {
      logic        wr;
      logic        known;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [31:0] busy;
      logic        err;
   } exp_rec_t;

   exp_rec_t    sbq[$];
   int          n_cmp;
   int          n_bad;
   logic [31:0] m_busy;
   logic        m_err;
   logic [4:0]  m_addr;
   logic [31:0] m_data;
   logic        m_known;

   rf_write_arbiter #(.STARVE_LIMIT(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .wb_valid    (wb_valid),
      .wb_ready    (wb_ready),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .lu_valid    (lu_valid),
      .lu_ready    (lu_ready),
      .lu_addr     (lu_addr),
      .lu_data     (lu_data),
      .issue_valid (issue_valid),
      .issue_addr  (issue_addr),
      .reg_write   (reg_write),
      .write_addr  (write_addr),
      .write_data  (write_data),
      .busy_mask   (busy_mask),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One arbitration cycle: drive, check grants, queue expected result, check after edge.
   task automatic step(input string tag,
                       input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic iv, input logic [4:0] ia,
                       input logic exp_wr, input logic exp_lr);
      exp_rec_t rec;
      @(negedge clk);
      wb_valid = wv; wb_addr = wa; wb_data = wd;
      lu_valid = lv; lu_addr = la; lu_data = ld;
      issue_valid = iv; issue_addr = ia;
      #1;
      check_eq({tag, ".wb_ready"}, {31'd0, wb_ready}, {31'd0, exp_wr});
      check_eq({tag, ".lu_ready"}, {31'd0, lu_ready}, {31'd0, exp_lr});
      if (exp_wr) begin
         m_addr = wa; m_data = wd; m_known = (wa != 5'd0);
      end else if (exp_lr) begin
         m_addr = la; m_data = ld; m_known = (la != 5'd0);
      end
      rec.wr    = (exp_wr && wa != 5'd0) || (exp_lr && la != 5'd0);
      rec.known = m_known;
      rec.addr  = m_addr;
      rec.data  = m_data;
      if (exp_lr && la != 5'd0 && !m_busy[la]) m_err = 1'b1;
      if (exp_lr) m_busy[la] = 1'b0;
      if (iv && ia != 5'd0) m_busy[ia] = 1'b1;
      rec.busy = m_busy;
      rec.err  = m_err;
      sbq.push_back(rec);
      @(posedge clk);
      #1;
      if (sbq.size() == 0) begin
         check_eq({tag, ".queue_empty"}, 32'd1, 32'd0);
      end else begin
         rec = sbq.pop_front();
         check_eq({tag, ".reg_write"}, {31'd0, reg_write}, {31'd0, rec.wr});
         if (rec.known) begin
            check_eq({tag, ".write_addr"}, {27'd0, write_addr}, {27'd0, rec.addr});
            check_eq({tag, ".write_data"}, write_data, rec.data);
         end
         check_eq({tag, ".busy_mask"}, busy_mask, rec.busy);
         check_eq({tag, ".err"}, {31'd0, err}, {31'd0, rec.err});
      end
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst = 1'b1;
      wb_valid = 1'b1; wb_addr = 5'd4;
      lu_valid = 1'b1; lu_addr = 5'd6;
      issue_valid = 1'b0;
      #1;
      check_eq({tag, ".rst_wb_ready"}, {31'd0, wb_ready}, 32'd0);
      check_eq({tag, ".rst_lu_ready"}, {31'd0, lu_ready}, 32'd0);
      @(posedge clk);
      #1;
      check_eq({tag, ".rst_reg_write"}, {31'd0, reg_write}, 32'd0);
      check_eq({tag, ".rst_write_addr"}, {27'd0, write_addr}, 32'd0);
      check_eq({tag, ".rst_write_data"}, write_data, 32'd0);
      check_eq({tag, ".rst_busy_mask"}, busy_mask, 32'd0);
      check_eq({tag, ".rst_err"}, {31'd0, err}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      wb_valid = 1'b0;
      lu_valid = 1'b0;
      m_busy = '0; m_err = 1'b0; m_addr = '0; m_data = '0; m_known = 1'b1;
      sbq.delete();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog expired");
   end

   initial begin
      n_cmp = 0; n_bad = 0;
      rst = 1'b1;
      wb_valid = 1'b0; wb_addr = '0; wb_data = '0;
      lu_valid = 1'b0; lu_addr = '0; lu_data = '0;
      issue_valid = 1'b0; issue_addr = '0;
      m_busy = '0; m_err = 1'b0; m_addr = '0; m_data = '0; m_known = 1'b1;

      do_reset("init");

      // Basic write-back, idle hold, addr-0 suppression.
      step("wb1",   1, 5'd1, 32'hDEADBEEF, 0, 5'd0, 32'h0, 0, 5'd0, 1, 0);
      step("idle1", 0, 5'd0, 32'h0,        0, 5'd0, 32'h0, 0, 5'd0, 0, 0);
      step("wb0",   1, 5'd0, 32'hFFFFFFFF, 0, 5'd0, 32'h0, 0, 5'd0, 1, 0);

      // Busy tracking and sticky err.
      step("iss5",   0, 5'd0, 32'h0, 0, 5'd0, 32'h0,        1, 5'd5, 0, 0);
      step("lu5",    0, 5'd0, 32'h0, 1, 5'd5, 32'h00000055, 0, 5'd0, 0, 1);
      step("iss5b",  0, 5'd0, 32'h0, 0, 5'd0, 32'h0,        1, 5'd5, 0, 0);
      step("isslu5", 0, 5'd0, 32'h0, 1, 5'd5, 32'h00000555, 1, 5'd5, 0, 1);
      step("lu7",    0, 5'd0, 32'h0, 1, 5'd7, 32'h00000077, 0, 5'd0, 0, 1);
      step("idle2",  0, 5'd0, 32'h0, 0, 5'd0, 32'h0,        0, 5'd0, 0, 0);
      step("idle3",  0, 5'd0, 32'h0, 0, 5'd0, 32'h0,        0, 5'd0, 0, 0);

      // Contention: four wb grants, then the starved lu, then wb again.
      for (int unsigned i = 0; i < 6; i++) begin
         step($sformatf("starve%0d", i),
              1, 5'd2, 32'h0000_0100 + i, 1, 5'd3, 32'h0000_0300 + i, 0, 5'd0,
              (i != 4), (i == 4));
      end
      step("idle4", 0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 5'd0, 0, 0);

      // In PRIO_LU, wb still wins while lu is idle; priority holds until an lu grant.
      for (int unsigned i = 0; i < 4; i++) begin
         step($sformatf("pl%0d", i),
              1, 5'd8, 32'hA000_0000 + i, 1, 5'd9, 32'hB000_0000 + i, 0, 5'd0, 1, 0);
      end
      step("pl_wbonly", 1, 5'd8, 32'hA000_0010, 0, 5'd9, 32'h0,          0, 5'd0, 1, 0);
      step("pl_lu",     1, 5'd8, 32'hA000_0011, 1, 5'd9, 32'hB000_0011, 0, 5'd0, 0, 1);
      step("pl_back",   1, 5'd8, 32'hA000_0012, 1, 5'd9, 32'hB000_0012, 0, 5'd0, 1, 0);
      step("idle5",     0, 5'd0, 32'h0,         0, 5'd0, 32'h0,         0, 5'd0, 0, 0);

      // Handshake immediately followed by reset, then contention grants wb.
      step("iss9", 0, 5'd0, 32'h0,        0, 5'd0, 32'h0, 1, 5'd9, 0, 0);
      step("wb9",  1, 5'd9, 32'h12345678, 0, 5'd0, 32'h0, 0, 5'd0, 1, 0);
      do_reset("rst2");
      step("post_rst", 1, 5'd10, 32'hCAFEF00D, 1, 5'd11, 32'hBEEFCAFE, 0, 5'd0, 1, 0);
      step("idle6",    0, 5'd0,  32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
